// File: rtl/mem_unit_if.sv
// Byte-wide request/grant bus between the memory stage and the memory controller.
interface mem_unit_if;
  logic        ram_req;
  logic        ram_wr;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        ram_gnt;

  modport master (
    output ram_req,
    output ram_wr,
    output ram_a,
    output ram_dout,
    input  ram_din,
    input  ram_gnt
  );

  modport slave (
    input  ram_req,
    input  ram_wr,
    input  ram_a,
    input  ram_dout,
    output ram_din,
    output ram_gnt
  );
endinterface

// File: rtl/mem_unit.sv
// MEM stage: serialises loads/stores into byte accesses and stalls the pipe.
// Define MEM_FW_EN to enable the MEM->ID forwarding outputs.
module mem_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_enable_i,
  input  logic        load_enable,
  input  logic        store_enable,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  load_store_type,
  mem_unit_if.master  ram,
  output logic [31:0] rd_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_enable_o,
  output logic        stall_req,
  output logic        mem_fw,
  output logic [4:0]  mem_fw_addr,
  output logic [31:0] mem_fw_data
);

  localparam logic [3:0] EXE_LB  = 4'd0;
  localparam logic [3:0] EXE_LH  = 4'd1;
  localparam logic [3:0] EXE_LW  = 4'd2;
  localparam logic [3:0] EXE_LBU = 4'd3;
  localparam logic [3:0] EXE_LHU = 4'd4;
  localparam logic [3:0] EXE_SB  = 4'd5;
  localparam logic [3:0] EXE_SH  = 4'd6;
  localparam logic [3:0] EXE_SW  = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_RD,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  k_q;
  logic [1:0]  last_q;
  logic [1:0]  last_d;
  logic        st_q;
  logic [3:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic        cap_q;
  logic [1:0]  cap_idx_q;
  logic [31:0] load_res;
  logic        req;
  logic        is_byte;
  logic        is_half;

  assign req = load_enable | store_enable;

  assign is_byte = (load_store_type == EXE_LB)
                 | (load_store_type == EXE_LBU)
                 | (load_store_type == EXE_SB);
  assign is_half = (load_store_type == EXE_LH)
                 | (load_store_type == EXE_LHU)
                 | (load_store_type == EXE_SH);

  always_comb begin
    last_d = 2'd3;
    unique case (1'b1)
      is_byte: last_d = 2'd0;
      is_half: last_d = 2'd1;
      default: last_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      last_q    <= '0;
      st_q      <= 1'b0;
      type_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= 1'b0;
      // read byte arrives one cycle after its grant
      if (cap_q)
        asm_q[{cap_idx_q, 3'b000} +: 8] <= ram.ram_din;
      case (state_q)
        IDLE: begin
          if (req) begin
            k_q     <= '0;
            last_q  <= last_d;
            st_q    <= store_enable;
            type_q  <= load_store_type;
            addr_q  <= mem_addr;
            wdata_q <= rd_data_i;
            asm_q   <= '0;
          end
        end
        ACCESS: begin
          if (ram.ram_gnt) begin
            k_q       <= k_q + 2'd1;
            cap_q     <= ~st_q;
            cap_idx_q <= k_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req)
          state_d = ACCESS;
      end
      ACCESS: begin
        if (ram.ram_gnt && (k_q == last_q))
          state_d = st_q ? DONE : WAIT_RD;
      end
      WAIT_RD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_res = asm_q;
    case (type_q)
      EXE_LB:  load_res = {{24{asm_q[7]}}, asm_q[7:0]};
      EXE_LH:  load_res = {{16{asm_q[15]}}, asm_q[15:0]};
      EXE_LBU: load_res = {24'd0, asm_q[7:0]};
      EXE_LHU: load_res = {16'd0, asm_q[15:0]};
      default: load_res = asm_q;
    endcase
  end

  always_comb begin
    ram.ram_req  = 1'b0;
    ram.ram_wr   = 1'b0;
    ram.ram_a    = '0;
    ram.ram_dout = '0;
    rd_data_o    = '0;
    rd_addr_o    = '0;
    rd_enable_o  = 1'b0;
    stall_req    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            stall_req = 1'b1;
          end else begin
            rd_data_o   = rd_data_i;
            rd_addr_o   = rd_addr_i;
            rd_enable_o = rd_enable_i;
          end
        end
        ACCESS: begin
          stall_req    = 1'b1;
          ram.ram_req  = 1'b1;
          ram.ram_wr   = st_q;
          ram.ram_a    = addr_q + {30'd0, k_q};
          ram.ram_dout = wdata_q[{k_q, 3'b000} +: 8];
        end
        WAIT_RD: stall_req = 1'b1;
        DONE: begin
          rd_data_o   = st_q ? rd_data_i : load_res;
          rd_addr_o   = rd_addr_i;
          rd_enable_o = ~st_q & rd_enable_i;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_FW_EN
  assign mem_fw      = stall_req ? 1'b0  : rd_enable_o;
  assign mem_fw_addr = stall_req ? 5'd0  : rd_addr_o;
  assign mem_fw_data = stall_req ? 32'd0 : rd_data_o;
`else
  assign mem_fw      = 1'b0;
  assign mem_fw_addr = 5'd0;
  assign mem_fw_data = 32'd0;
`endif

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit with a byte-serial memory controller model.
module tb_mem_unit;

  localparam logic [3:0] LB  = 4'd0;
  localparam logic [3:0] LH  = 4'd1;
  localparam logic [3:0] LW  = 4'd2;
  localparam logic [3:0] LBU = 4'd3;
  localparam logic [3:0] LHU = 4'd4;
  localparam logic [3:0] SB  = 4'd5;
  localparam logic [3:0] SH  = 4'd6;
  localparam logic [3:0] SW  = 4'd7;

`ifdef MEM_FW_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_enable_i;
  logic        load_enable;
  logic        store_enable;
  logic [31:0] mem_addr;
  logic [3:0]  load_store_type;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
  logic        stall_req;
  logic        mem_fw;
  logic [4:0]  mem_fw_addr;
  logic [31:0] mem_fw_data;

  mem_unit_if ram_bus ();

  mem_unit dut (
    .clk             (clk),
    .rst             (rst),
    .rd_data_i       (rd_data_i),
    .rd_addr_i       (rd_addr_i),
    .rd_enable_i     (rd_enable_i),
    .load_enable     (load_enable),
    .store_enable    (store_enable),
    .mem_addr        (mem_addr),
    .load_store_type (load_store_type),
    .ram             (ram_bus),
    .rd_data_o       (rd_data_o),
    .rd_addr_o       (rd_addr_o),
    .rd_enable_o     (rd_enable_o),
    .stall_req       (stall_req),
    .mem_fw          (mem_fw),
    .mem_fw_addr     (mem_fw_addr),
    .mem_fw_data     (mem_fw_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] req_a_q[$];
  logic [7:0]  wr_q[$];
  logic [7:0]  rd_bytes[$];
  int          lat;
  int          hold_k;
  int          hold_n;
  logic [31:0] d_data;
  logic [4:0]  d_addr;
  logic        d_en;
  logic [31:0] d_fw_data;
  logic        fw_bad;
  logic        stall0;

  task automatic do_op(input logic ld, input logic st,
                       input logic [3:0] typ, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd,
                       input logic rde);
    int bidx;
    int wcnt;
    logic pend;
    logic [7:0] din_n;
    req_a_q.delete();
    wr_q.delete();
    lat = -1;
    fw_bad = 1'b0;
    bidx = 0;
    wcnt = 0;
    pend = 1'b0;
    din_n = 8'h00;
    @(negedge clk);
    load_enable = ld;
    store_enable = st;
    load_store_type = typ;
    mem_addr = addr;
    rd_data_i = data;
    rd_addr_i = rd;
    rd_enable_i = rde;
    ram_bus.ram_gnt = 1'b1;
    ram_bus.ram_din = 8'h00;
    #1;
    stall0 = stall_req;
    if (mem_fw !== 1'b0 || mem_fw_data !== 32'd0) fw_bad = 1'b1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      ram_bus.ram_din = pend ? din_n : 8'h00;
      pend = 1'b0;
      ram_bus.ram_gnt = 1'b0;
      #1;
      if (stall_req === 1'b0) begin
        lat = c;
        d_data = rd_data_o;
        d_addr = rd_addr_o;
        d_en = rd_enable_o;
        d_fw_data = mem_fw_data;
      end else begin
        if (mem_fw !== 1'b0 || mem_fw_data !== 32'd0 || mem_fw_addr !== 5'd0)
          fw_bad = 1'b1;
        if (ram_bus.ram_req === 1'b1) begin
          req_a_q.push_back(ram_bus.ram_a);
          if (bidx == hold_k && wcnt < hold_n) begin
            wcnt++;
          end else begin
            ram_bus.ram_gnt = 1'b1;
            bidx++;
            if (ram_bus.ram_wr) begin
              wr_q.push_back(ram_bus.ram_dout);
            end else begin
              pend = 1'b1;
              din_n = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'h00;
            end
          end
        end
      end
    end
    if (lat < 0)
      $display("FAIL op_timeout: no DONE within 40 cycles (type %0d)", typ);
    @(negedge clk);
    load_enable = 1'b0;
    store_enable = 1'b0;
    rd_enable_i = 1'b0;
    ram_bus.ram_gnt = 1'b0;
    hold_k = 0;
    hold_n = 0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_data_i = 32'h1234_5678;
    rd_addr_i = 5'd9;
    rd_enable_i = 1'b1;
    load_enable = 1'b1;
    #1;
    checks++;
    if (rd_data_o !== 32'd0 || rd_enable_o !== 1'b0 || rd_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_rd: got %h/%0d/%b expected 0/0/0", rd_data_o, rd_addr_o, rd_enable_o);
    end
    checks++;
    if (stall_req !== 1'b0 || ram_bus.ram_req !== 1'b0 || ram_bus.ram_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_ram: stall %b req %b a %h expected 0 0 0", stall_req, ram_bus.ram_req, ram_bus.ram_a);
    end
    checks++;
    if (mem_fw !== 1'b0 || mem_fw_data !== 32'd0 || mem_fw_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_fw: got %b %h expected 0 0", mem_fw, mem_fw_data);
    end
    load_enable = 1'b0;
    rd_enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    rd_data_i = 32'h55;
    rd_addr_i = 5'd7;
    rd_enable_i = 1'b1;
    #1;
    checks++;
    if (rd_data_o !== 32'h55 || rd_addr_o !== 5'd7 || rd_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL pass_rd: got %h/%0d/%b expected 55/7/1", rd_data_o, rd_addr_o, rd_enable_o);
    end
    checks++;
    if (stall_req !== 1'b0 || ram_bus.ram_req !== 1'b0) begin
      errors++;
      $display("FAIL pass_stall: stall %b req %b expected 0 0", stall_req, ram_bus.ram_req);
    end
    checks++;
    if (mem_fw_data !== (FW ? 32'h55 : 32'd0) || mem_fw !== FW) begin
      errors++;
      $display("FAIL pass_fw: got %b %h expected %b %h", mem_fw, mem_fw_data, FW, FW ? 32'h55 : 32'd0);
    end
    rd_enable_i = 1'b0;
  endtask

  task automatic test_sw();
    logic [7:0] eb[4];
    eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_op(1'b0, 1'b1, SW, 32'h100, 32'hDEAD_BEEF, 5'd3, 1'b1);
    checks++;
    if (lat != 5 || stall0 !== 1'b1) begin
      errors++;
      $display("FAIL sw_latency: got %0d stall0 %b expected 5 1", lat, stall0);
    end
    checks++;
    if (wr_q.size() != 4 || req_a_q.size() != 4) begin
      errors++;
      $display("FAIL sw_count: got %0d writes %0d reqs expected 4 4", wr_q.size(), req_a_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_q[i] !== eb[i] || req_a_q[i] !== 32'h100 + i) begin
          errors++;
          $display("FAIL sw_byte%0d: got %h@%h expected %h@%h", i, wr_q[i], req_a_q[i], eb[i], 32'h100 + i);
        end
      end
    end
    checks++;
    if (d_en !== 1'b0 || fw_bad !== 1'b0) begin
      errors++;
      $display("FAIL sw_done: en %b fw_bad %b expected 0 0", d_en, fw_bad);
    end
  endtask

  task automatic test_sh();
    do_op(1'b0, 1'b1, SH, 32'h40, 32'hA5A5_1234, 5'd4, 1'b0);
    checks++;
    if (lat != 3 || wr_q.size() != 2) begin
      errors++;
      $display("FAIL sh_shape: got lat %0d writes %0d expected 3 2", lat, wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 8'h34 || wr_q[1] !== 8'h12 || req_a_q[1] !== 32'h41) begin
        errors++;
        $display("FAIL sh_bytes: got %h %h @%h expected 34 12 @41", wr_q[0], wr_q[1], req_a_q[1]);
      end
    end
  endtask

  task automatic test_lb();
    rd_bytes = '{8'h80};
    do_op(1'b1, 1'b0, LB, 32'h20, 32'h0, 5'd12, 1'b1);
    checks++;
    if (d_data !== 32'hFFFF_FF80 || lat != 3) begin
      errors++;
      $display("FAIL lb_sext: got %h lat %0d expected ffffff80 3", d_data, lat);
    end
    checks++;
    if (d_en !== 1'b1 || d_addr !== 5'd12 || req_a_q.size() != 1) begin
      errors++;
      $display("FAIL lb_wb: got en %b rd %0d reqs %0d expected 1 12 1", d_en, d_addr, req_a_q.size());
    end
    checks++;
    if (d_fw_data !== (FW ? 32'hFFFF_FF80 : 32'd0)) begin
      errors++;
      $display("FAIL lb_fw: got %h expected %h", d_fw_data, FW ? 32'hFFFF_FF80 : 32'd0);
    end
    rd_bytes = '{8'h80};
    do_op(1'b1, 1'b0, LBU, 32'h20, 32'h0, 5'd12, 1'b1);
    checks++;
    if (d_data !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_zext: got %h expected 00000080", d_data);
    end
  endtask

  task automatic test_lh_wait();
    logic [31:0] ea[5];
    ea = '{32'h31, 32'h32, 32'h32, 32'h32, 32'h32};
    rd_bytes = '{8'h34, 8'h92};
    hold_k = 1;
    hold_n = 3;
    do_op(1'b1, 1'b0, LH, 32'h31, 32'h0, 5'd2, 1'b1);
    checks++;
    if (d_data !== 32'hFFFF_9234 || lat != 7) begin
      errors++;
      $display("FAIL lh_wait: got %h lat %0d expected ffff9234 7", d_data, lat);
    end
    checks++;
    if (req_a_q.size() != 5) begin
      errors++;
      $display("FAIL lh_reqs: got %0d expected 5", req_a_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (req_a_q[i] !== ea[i]) begin
          errors++;
          $display("FAIL lh_addr%0d: got %h expected %h", i, req_a_q[i], ea[i]);
        end
      end
    end
    checks++;
    if (fw_bad !== 1'b0) begin
      errors++;
      $display("FAIL lh_fw_stall: got %b expected 0", fw_bad);
    end
    rd_bytes = '{8'h34, 8'h92};
    do_op(1'b1, 1'b0, LHU, 32'h31, 32'h0, 5'd2, 1'b1);
    checks++;
    if (d_data !== 32'h0000_9234 || lat != 4) begin
      errors++;
      $display("FAIL lhu_zext: got %h lat %0d expected 00009234 4", d_data, lat);
    end
  endtask

  task automatic test_lw_wrap();
    logic [31:0] ea[4];
    ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_op(1'b1, 1'b0, LW, 32'hFFFF_FFFE, 32'h0, 5'd31, 1'b1);
    checks++;
    if (d_data !== 32'h4433_2211 || lat != 6) begin
      errors++;
      $display("FAIL lw_data: got %h lat %0d expected 44332211 6", d_data, lat);
    end
    checks++;
    if (req_a_q.size() != 4) begin
      errors++;
      $display("FAIL lw_reqs: got %0d expected 4", req_a_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (req_a_q[i] !== ea[i]) begin
          errors++;
          $display("FAIL lw_addr%0d: got %h expected %h", i, req_a_q[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    store_enable = 1'b1;
    load_store_type = SW;
    mem_addr = 32'h300;
    rd_data_i = 32'h1122_3344;
    rd_addr_i = 5'd1;
    ram_bus.ram_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ram_bus.ram_gnt = 1'b0;
    #1;
    checks++;
    if (ram_bus.ram_a !== 32'h302 || ram_bus.ram_dout !== 8'h22) begin
      errors++;
      $display("FAIL mid_progress: got %h %h expected 302 22", ram_bus.ram_a, ram_bus.ram_dout);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_bus.ram_req !== 1'b0 || ram_bus.ram_a !== 32'd0 || ram_bus.ram_dout !== 8'd0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: req %b a %h dout %h stall %b expected all 0", ram_bus.ram_req, ram_bus.ram_a, ram_bus.ram_dout, stall_req);
    end
    store_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 1'b1, SB, 32'h200, 32'h77, 5'd1, 1'b1);
    checks++;
    if (lat != 2 || wr_q.size() != 1 || req_a_q.size() != 1) begin
      errors++;
      $display("FAIL mid_restart: lat %0d writes %0d expected 2 1", lat, wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 8'h77 || req_a_q[0] !== 32'h200) begin
        errors++;
        $display("FAIL mid_sb: got %h@%h expected 77@200", wr_q[0], req_a_q[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_data_i = '0;
    rd_addr_i = '0;
    rd_enable_i = 1'b0;
    load_enable = 1'b0;
    store_enable = 1'b0;
    mem_addr = '0;
    load_store_type = '0;
    ram_bus.ram_gnt = 1'b0;
    ram_bus.ram_din = '0;
    hold_k = 0;
    hold_n = 0;
    test_reset();
    test_passthrough();
    test_sw();
    test_sh();
    test_lb();
    test_lh_wait();
    test_lw_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
